// File: rtl/sign_extension_pkg.sv
// Shared decode-stage constants: immediate/register widths and extension modes.
package sign_extension_pkg;

    localparam int unsigned IMM_WIDTH = 16;
    localparam int unsigned REG_WIDTH = 32;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_BYTE  = 2'b10,
        EXT_UPPER = 2'b11
    } ext_mode_e;

endpackage

// File: rtl/sign_extension_if.sv
// Immediate-extension bus: control, raw immediate and extended results.
interface sign_extension_if #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 32
);

    logic                 I_LOCK;
    logic                 I_Valid;
    logic [1:0]           I_Mode;
    logic [IN_WIDTH-1:0]  In;
    logic [OUT_WIDTH-1:0] Out;
    logic [OUT_WIDTH-1:0] O_OutReg;
    logic                 O_Valid;

    modport master (
        output I_LOCK, I_Valid, I_Mode, In,
        input  Out, O_OutReg, O_Valid
    );

    modport slave (
        input  I_LOCK, I_Valid, I_Mode, In,
        output Out, O_OutReg, O_Valid
    );

endinterface

// File: rtl/sign_extension_core.sv
// Purely combinational extension-mode mux.
module sign_extension_core
    import sign_extension_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IMM_WIDTH,
    parameter int unsigned OUT_WIDTH = REG_WIDTH
) (
    input  logic [1:0]           Mode,
    input  logic [IN_WIDTH-1:0]  In,
    output logic [OUT_WIDTH-1:0] Out
);

    localparam int unsigned PAD = OUT_WIDTH - IN_WIDTH;

    if (OUT_WIDTH < IN_WIDTH || IN_WIDTH < 8) begin : g_bad_params
        $error("sign_extension_core: need OUT_WIDTH >= IN_WIDTH and IN_WIDTH >= 8");
    end

    logic [OUT_WIDTH-1:0] sign_ext;
    logic [OUT_WIDTH-1:0] zero_ext;
    logic [OUT_WIDTH-1:0] byte_ext;
    logic [OUT_WIDTH-1:0] upper_ext;

    // Build every candidate, then select by mode. With PAD == 0 the upper
    // shift is a no-op, so upper mode collapses onto zero extension.
    always_comb begin
        sign_ext  = OUT_WIDTH'($signed(In));
        zero_ext  = OUT_WIDTH'(In);
        byte_ext  = OUT_WIDTH'($signed(In[7:0]));
        upper_ext = zero_ext << PAD;
        Out       = sign_ext;
        case (Mode)
            EXT_SIGN:  Out = sign_ext;
            EXT_ZERO:  Out = zero_ext;
            EXT_BYTE:  Out = byte_ext;
            EXT_UPPER: Out = upper_ext;
            default:   Out = sign_ext;
        endcase
    end

endmodule

// File: rtl/sign_extension.sv
// Immediate-generation unit: combinational extension plus a lockable register stage.
module sign_extension
    import sign_extension_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IMM_WIDTH,
    parameter int unsigned OUT_WIDTH = REG_WIDTH
) (
    input  logic             I_CLOCK,
    input  logic             I_RESET,
    sign_extension_if.slave  bus
);

    logic [OUT_WIDTH-1:0] ext_value;

    sign_extension_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .Mode (bus.I_Mode),
        .In   (bus.In),
        .Out  (ext_value)
    );

    // Combinational result goes straight out; decode samples it same cycle.
    always_comb begin
        bus.Out = ext_value;
    end

    // Pipelined copy: cleared asynchronously, captured only when the pipe advances.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            bus.O_OutReg <= '0;
            bus.O_Valid  <= 1'b0;
        end else if (bus.I_LOCK) begin
            bus.O_OutReg <= ext_value;
            bus.O_Valid  <= bus.I_Valid;
        end
    end

endmodule

// File: tb/tb_sign_extension.sv
// Directed self-checking bench for sign_extension.
module tb_sign_extension;

    logic I_CLOCK;
    logic I_RESET;
    int   checks;
    int   failures;

    sign_extension_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus_if ();

    sign_extension #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .I_CLOCK (I_CLOCK),
        .I_RESET (I_RESET),
        .bus     (bus_if.slave)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    // Reference extension written out for the fixed 16->32 configuration.
    function automatic logic [31:0] ref_ext(input logic [1:0] mode, input logic [15:0] v);
        case (mode)
            2'b00:   return {{16{v[15]}}, v};
            2'b01:   return {16'h0000, v};
            2'b10:   return {{24{v[7]}}, v[7:0]};
            default: return {v, 16'h0000};
        endcase
    endfunction

    task automatic test_reset();
        I_RESET        = 1'b1;
        bus_if.I_LOCK  = 1'b1;
        bus_if.I_Valid = 1'b1;
        bus_if.I_Mode  = 2'b00;
        bus_if.In      = 16'h1234;
        repeat (2) @(posedge I_CLOCK);
        #1;
        checks++;
        if (bus_if.O_OutReg !== 32'h0) begin
            failures++;
            $display("FAIL reset_outreg got=%h exp=%h", bus_if.O_OutReg, 32'h0);
        end
        checks++;
        if (bus_if.O_Valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=%b", bus_if.O_Valid, 1'b0);
        end
        @(negedge I_CLOCK);
        I_RESET       = 1'b0;
        bus_if.I_LOCK = 1'b0;
    endtask

    task automatic test_comb(input string name, input logic [1:0] mode,
                             input logic [15:0] v, input logic [31:0] exp);
        bus_if.I_Mode = mode;
        bus_if.In     = v;
        #1;
        checks++;
        if (bus_if.Out !== exp) begin
            failures++;
            $display("FAIL %s in=%h got=%h exp=%h", name, v, bus_if.Out, exp);
        end
    endtask

    task automatic test_modes();
        test_comb("sign_fffe",  2'b00, 16'hFFFE, 32'hFFFFFFFE);
        test_comb("sign_0002",  2'b00, 16'h0002, 32'h00000002);
        test_comb("sign_8000",  2'b00, 16'h8000, 32'hFFFF8000);
        test_comb("sign_7fff",  2'b00, 16'h7FFF, 32'h00007FFF);
        test_comb("zero_8001",  2'b01, 16'h8001, 32'h00008001);
        test_comb("upper_1234", 2'b11, 16'h1234, 32'h12340000);
        test_comb("byte_7f80",  2'b10, 16'h7F80, 32'hFFFFFF80);
        test_comb("byte_807f",  2'b10, 16'h807F, 32'h0000007F);
    endtask

    task automatic test_registered();
        @(negedge I_CLOCK);
        bus_if.I_LOCK  = 1'b1;
        bus_if.I_Valid = 1'b1;
        bus_if.I_Mode  = 2'b00;
        bus_if.In      = 16'h8000;
        @(posedge I_CLOCK);
        #1;
        checks++;
        if (bus_if.O_OutReg !== 32'hFFFF8000) begin
            failures++;
            $display("FAIL reg_capture got=%h exp=%h", bus_if.O_OutReg, 32'hFFFF8000);
        end
        checks++;
        if (bus_if.O_Valid !== 1'b1) begin
            failures++;
            $display("FAIL reg_valid got=%b exp=%b", bus_if.O_Valid, 1'b1);
        end
        @(negedge I_CLOCK);
        bus_if.I_LOCK  = 1'b0;
        bus_if.I_Valid = 1'b0;
        bus_if.In      = 16'h0001;
        @(posedge I_CLOCK);
        #1;
        checks++;
        if (bus_if.O_OutReg !== 32'hFFFF8000) begin
            failures++;
            $display("FAIL reg_hold got=%h exp=%h", bus_if.O_OutReg, 32'hFFFF8000);
        end
        checks++;
        if (bus_if.O_Valid !== 1'b1) begin
            failures++;
            $display("FAIL reg_hold_valid got=%b exp=%b", bus_if.O_Valid, 1'b1);
        end
        checks++;
        if (bus_if.Out !== 32'h00000001) begin
            failures++;
            $display("FAIL comb_while_locked got=%h exp=%h", bus_if.Out, 32'h00000001);
        end
    endtask

    task automatic test_async_reset();
        @(negedge I_CLOCK);
        #2;
        I_RESET       = 1'b1;
        bus_if.I_Mode = 2'b11;
        bus_if.In     = 16'hABCD;
        #1;
        checks++;
        if (bus_if.O_OutReg !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_outreg got=%h exp=%h", bus_if.O_OutReg, 32'h0);
        end
        checks++;
        if (bus_if.O_Valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_valid got=%b exp=%b", bus_if.O_Valid, 1'b0);
        end
        checks++;
        if (bus_if.Out !== 32'hABCD0000) begin
            failures++;
            $display("FAIL comb_in_reset got=%h exp=%h", bus_if.Out, 32'hABCD0000);
        end
        // Release with lock low: nothing captured yet.
        @(negedge I_CLOCK);
        I_RESET        = 1'b0;
        bus_if.I_LOCK  = 1'b0;
        bus_if.I_Valid = 1'b1;
        @(posedge I_CLOCK);
        #1;
        checks++;
        if (bus_if.O_Valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_nolock got=%b exp=%b", bus_if.O_Valid, 1'b0);
        end
        // First locked edge captures.
        @(negedge I_CLOCK);
        bus_if.I_LOCK = 1'b1;
        bus_if.I_Mode = 2'b10;
        bus_if.In     = 16'h0080;
        @(posedge I_CLOCK);
        #1;
        checks++;
        if (bus_if.O_OutReg !== 32'hFFFFFF80 || bus_if.O_Valid !== 1'b1) begin
            failures++;
            $display("FAIL first_capture got=%h/%b exp=%h/%b",
                     bus_if.O_OutReg, bus_if.O_Valid, 32'hFFFFFF80, 1'b1);
        end
        @(negedge I_CLOCK);
        bus_if.I_LOCK = 1'b0;
    endtask

    task automatic test_sweep();
        for (int m = 0; m < 4; m++) begin
            int mism;
            logic [1:0]  mode;
            logic [31:0] first_got;
            logic [31:0] first_exp;
            mism      = 0;
            mode      = 2'(m);
            first_got = '0;
            first_exp = '0;
            for (int v = 0; v < 65536; v++) begin
                bus_if.I_Mode = mode;
                bus_if.In     = 16'(v);
                #1;
                if (bus_if.Out !== ref_ext(mode, 16'(v))) begin
                    if (mism == 0) begin
                        first_got = bus_if.Out;
                        first_exp = ref_ext(mode, 16'(v));
                    end
                    mism++;
                end
            end
            checks++;
            if (mism !== 0) begin
                failures++;
                $display("FAIL sweep_mode%0d mismatches=%0d exp=0 first_got=%h first_exp=%h",
                         m, mism, first_got, first_exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_modes();
        test_registered();
        test_async_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
